// File: rtl/float_rob_commit.sv
// float_rob_commit: 15-entry reorder buffer for the FP register file.
// Hands out tags 1..15 at dispatch, captures results from two CDB ports and
// retires up to two completed entries per cycle in program order.
module float_rob_commit #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_a,
   input  logic              alloc_b,
   input  logic [4:0]        alloc_wn_a,
   input  logic [4:0]        alloc_wn_b,
   output logic              alloc_ready,
   output logic              wlwta,
   output logic              wlwtb,
   output logic [4:0]        wlwt_wna,
   output logic [4:0]        wlwt_wnb,
   output logic [IDX_W-1:0]  wlwt_ROB_index_a,
   output logic [IDX_W-1:0]  wlwt_ROB_index_b,
   input  logic              cdb_valid_a,
   input  logic              cdb_valid_b,
   input  logic [IDX_W-1:0]  cdb_tag_a,
   input  logic [IDX_W-1:0]  cdb_tag_b,
   input  logic [DATA_W-1:0] cdb_data_a,
   input  logic [DATA_W-1:0] cdb_data_b,
   input  logic              flush,
   output logic              wea,
   output logic              web,
   output logic [4:0]        wna,
   output logic [4:0]        wnb,
   output logic [IDX_W-1:0]  ROB_index_wta,
   output logic [IDX_W-1:0]  ROB_index_wtb,
   output logic [DATA_W-1:0] dataina,
   output logic [DATA_W-1:0] datainb,
   output logic [IDX_W-1:0]  count
);

   localparam int NENT = (1 << IDX_W) - 1;
   localparam logic [IDX_W-1:0] TAG_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] TAG_LAST = IDX_W'(NENT);

   // Tag 0 is reserved as "no pending writer", so pointers wrap from the last tag to 1
   function automatic logic [IDX_W-1:0] nextTag(input logic [IDX_W-1:0] t);
      return (t == TAG_LAST) ? TAG_ONE : t + TAG_ONE;
   endfunction

   logic [NENT:1]     r_valid;
   logic [NENT:1]     r_done;
   logic [4:0]        r_wn   [1:NENT];
   logic [DATA_W-1:0] r_data [1:NENT];
   logic [IDX_W-1:0]  r_head;
   logic [IDX_W-1:0]  r_tail;
   logic [IDX_W-1:0]  r_count;
   logic              r_wea;
   logic              r_web;
   logic [4:0]        r_wna;
   logic [4:0]        r_wnb;
   logic [IDX_W-1:0]  r_idxA;
   logic [IDX_W-1:0]  r_idxB;
   logic [DATA_W-1:0] r_dinA;
   logic [DATA_W-1:0] r_dinB;

   logic              w_ready;
   logic              w_accA;
   logic              w_accB;
   logic [IDX_W-1:0]  w_tagA;
   logic [IDX_W-1:0]  w_tagB;
   logic [IDX_W-1:0]  w_tailNext;
   logic [IDX_W-1:0]  w_nAlloc;
   logic [IDX_W-1:0]  w_head1;
   logic              w_retA;
   logic              w_retB;
   logic [IDX_W-1:0]  w_headNext;
   logic [IDX_W-1:0]  w_nRet;
   logic              w_cdbHitA;
   logic              w_cdbHitB;

   // Dispatch: accept only with two free slots; B takes the slot after A when both go
   always_comb begin
      w_ready    = (r_count <= IDX_W'(NENT - 2));
      w_accA     = alloc_a & w_ready;
      w_accB     = alloc_b & w_ready;
      w_tagA     = r_tail;
      w_tagB     = w_accA ? nextTag(r_tail) : r_tail;
      w_tailNext = r_tail;
      if (w_accA && w_accB) begin
         w_tailNext = nextTag(nextTag(r_tail));
      end else if (w_accA || w_accB) begin
         w_tailNext = nextTag(r_tail);
      end
      w_nAlloc   = IDX_W'(w_accA) + IDX_W'(w_accB);
   end

   // Commit selection looks only at registered state, so a same-cycle CDB write cannot retire
   always_comb begin
      w_head1    = nextTag(r_head);
      w_retA     = r_valid[r_head] & r_done[r_head];
      w_retB     = w_retA & r_valid[w_head1] & r_done[w_head1];
      w_headNext = r_head;
      if (w_retB) begin
         w_headNext = nextTag(w_head1);
      end else if (w_retA) begin
         w_headNext = w_head1;
      end
      w_nRet     = IDX_W'(w_retA) + IDX_W'(w_retB);
      w_cdbHitA  = cdb_valid_a && (cdb_tag_a != '0) && r_valid[cdb_tag_a];
      w_cdbHitB  = cdb_valid_b && (cdb_tag_b != '0) && r_valid[cdb_tag_b];
   end

   // Buffer state and registered commit ports; flush outranks everything but reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_done  <= '0;
         for (int i = 1; i <= NENT; i++) begin
            r_wn[i]   <= '0;
            r_data[i] <= '0;
         end
         r_head  <= TAG_ONE;
         r_tail  <= TAG_ONE;
         r_count <= '0;
         r_wea   <= 1'b0;
         r_web   <= 1'b0;
         r_wna   <= '0;
         r_wnb   <= '0;
         r_idxA  <= '0;
         r_idxB  <= '0;
         r_dinA  <= '0;
         r_dinB  <= '0;
      end else if (flush) begin
         r_valid <= '0;
         r_done  <= '0;
         r_head  <= TAG_ONE;
         r_tail  <= TAG_ONE;
         r_count <= '0;
         r_wea   <= 1'b0;
         r_web   <= 1'b0;
      end else begin
         if (w_cdbHitA) begin
            r_done[cdb_tag_a] <= 1'b1;
            r_data[cdb_tag_a] <= cdb_data_a;
         end
         if (w_cdbHitB) begin
            r_done[cdb_tag_b] <= 1'b1;
            r_data[cdb_tag_b] <= cdb_data_b;
         end
         r_wea <= w_retA && (r_wn[r_head] != 5'd0);
         r_web <= w_retB && (r_wn[w_head1] != 5'd0);
         if (w_retA) begin
            r_wna            <= r_wn[r_head];
            r_idxA           <= r_head;
            r_dinA           <= r_data[r_head];
            r_valid[r_head]  <= 1'b0;
            r_done[r_head]   <= 1'b0;
         end
         if (w_retB) begin
            r_wnb            <= r_wn[w_head1];
            r_idxB           <= w_head1;
            r_dinB           <= r_data[w_head1];
            r_valid[w_head1] <= 1'b0;
            r_done[w_head1]  <= 1'b0;
         end
         if (w_accA) begin
            r_valid[w_tagA] <= 1'b1;
            r_done[w_tagA]  <= 1'b0;
            r_wn[w_tagA]    <= alloc_wn_a;
         end
         if (w_accB) begin
            r_valid[w_tagB] <= 1'b1;
            r_done[w_tagB]  <= 1'b0;
            r_wn[w_tagB]    <= alloc_wn_b;
         end
         r_head  <= w_headNext;
         r_tail  <= w_tailNext;
         r_count <= r_count + w_nAlloc - w_nRet;
      end
   end

   assign alloc_ready      = w_ready;
   assign wlwta            = w_accA;
   assign wlwtb            = w_accB;
   assign wlwt_wna         = alloc_wn_a;
   assign wlwt_wnb         = alloc_wn_b;
   assign wlwt_ROB_index_a = w_tagA;
   assign wlwt_ROB_index_b = w_tagB;
   assign wea              = r_wea;
   assign web              = r_web;
   assign wna              = r_wna;
   assign wnb              = r_wnb;
   assign ROB_index_wta    = r_idxA;
   assign ROB_index_wtb    = r_idxB;
   assign dataina          = r_dinA;
   assign datainb          = r_dinB;
   assign count            = r_count;

endmodule
